// File: rtl/sincos_share_ctrl_pkg.sv
// Shared definitions for the Sin_Cos sharing controller: FSM encoding,
// float constants and helpers for sizing index fields.
package sincos_share_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic        ONE     = 1'b1;
    localparam logic        ZERO    = 1'b0;

    // Width of a requester index; at least one bit even for a single lane.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must reach max_val.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sincos_share_ctrl_arb.sv
// Round-robin arbiter: picks the first requesting lane after ptr (wrapping).
// Ports: req (request vector), ptr (last granted lane), grant (one-hot),
//        idx (binary index of grant), any (some lane requested).
module sincos_share_ctrl_arb
    import sincos_share_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    // Scan lanes ptr+1 .. ptr+NUM_REQ, keep the first hit.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = ZERO;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            int unsigned j;
            j = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = ONE;
                grant[j] = ONE;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/sincos_share_ctrl.sv
// Shares one Sin_Cos float unit between NUM_REQ requesters. One theta is
// accepted per transaction (round-robin), the unit is driven until its valid
// (after MIN_LAT ignored cycles) or until TIMEOUT, and sin/cos go back to the
// owning lane as a one-cycle pulse.
// Ports: i_req_valid/i_req_th (requests), o_req_ready (combinational accept),
//        o_rsp_valid/o_rsp_sin/o_rsp_cos/o_rsp_err (responses),
//        o_sc_ena/o_sc_th, i_sc_sin/i_sc_cos/i_sc_valid (Sin_Cos side),
//        o_busy (not idle).
module sincos_share_ctrl
    import sincos_share_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WL      = 32,
    parameter int unsigned MIN_LAT = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*WL-1:0] i_req_th,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    output logic [WL-1:0]         o_rsp_sin,
    output logic [WL-1:0]         o_rsp_cos,
    output logic                  o_rsp_err,
    output logic                  o_sc_ena,
    output logic [WL-1:0]         o_sc_th,
    input  logic [WL-1:0]         i_sc_sin,
    input  logic [WL-1:0]         i_sc_cos,
    input  logic                  i_sc_valid,
    output logic                  o_busy
);

    localparam int unsigned ID_W  = id_w(NUM_REQ);
    localparam int unsigned CNT_W = cnt_w(TIMEOUT);

    state_t               state, state_n;
    logic [ID_W-1:0]      ptr, ptr_n;
    logic [ID_W-1:0]      id_q, id_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [WL-1:0]        th_n, sin_n, cos_n;
    logic                 err_n, ena_n, busy_n;
    logic [NUM_REQ-1:0]   rv_n;
    logic [NUM_REQ-1:0]   gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic                 gnt_any;

    sincos_share_ctrl_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // Accept is combinational in IDLE; suppressed while reset is held.
    assign o_req_ready = (state == S_IDLE && !i_rst) ? gnt : '0;

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        id_n    = id_q;
        cnt_n   = cnt;
        th_n    = o_sc_th;
        sin_n   = o_rsp_sin;
        cos_n   = o_rsp_cos;
        err_n   = o_rsp_err;
        ena_n   = ZERO;
        rv_n    = '0;
        busy_n  = ONE;

        unique case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    ptr_n   = gnt_idx;
                    id_n    = gnt_idx;
                    th_n    = i_req_th[int'(gnt_idx)*WL +: WL];
                    cnt_n   = '0;
                    ena_n   = ONE;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                ena_n = ONE;
                cnt_n = cnt + CNT_W'(1);
                // Valid in the first MIN_LAT cycles may be left over from the previous op.
                if (i_sc_valid && cnt >= CNT_W'(MIN_LAT)) begin
                    sin_n       = i_sc_sin;
                    cos_n       = i_sc_cos;
                    err_n       = ZERO;
                    ena_n       = ZERO;
                    rv_n[id_q]  = ONE;
                    state_n     = S_RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    sin_n       = WL'(FP_ZERO);
                    cos_n       = WL'(FP_ZERO);
                    err_n       = ONE;
                    ena_n       = ZERO;
                    rv_n[id_q]  = ONE;
                    state_n     = S_RESP;
                end
            end
            S_RESP: begin
                state_n = S_GAP;
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            ptr         <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            cnt         <= '0;
            o_sc_ena    <= ZERO;
            o_sc_th     <= '0;
            o_rsp_valid <= '0;
            o_rsp_sin   <= '0;
            o_rsp_cos   <= '0;
            o_rsp_err   <= ZERO;
            o_busy      <= ZERO;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            id_q        <= id_n;
            cnt         <= cnt_n;
            o_sc_ena    <= ena_n;
            o_sc_th     <= th_n;
            o_rsp_valid <= rv_n;
            o_rsp_sin   <= sin_n;
            o_rsp_cos   <= cos_n;
            o_rsp_err   <= err_n;
            o_busy      <= busy_n;
        end
    end

endmodule
